// File: rtl/serial_to_parallel_receiver.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_receiver
//
// Purpose:
//   Reassembles an LSB-first serial frame into a DATA_W-bit word and holds it
//   in a valid/ready output register. Frame format: start bit '1', DATA_W data
//   bits (LSB first), then an optional even-parity bit. The idle line is '0'.
//   The input is sampled only on clock edges where bit_en=1.
//
// Build option:
//   PARITY_CHECK_EN - when defined, a parity bit follows the data bits and is
//                     checked. A mismatch pulses parity_err and drops the word.
//                     When undefined, the word is captured on the last data bit
//                     and parity_err is constant 0.
//
// Ports:
//   clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-high reset
//   bit_en        in   1       bit strobe; serial_in sampled only when 1
//   serial_in     in   1       serial data line (idle '0')
//   parallel_out  out  DATA_W  assembled word (output register)
//   out_valid     out  1       parallel_out holds an unconsumed word
//   out_ready     in   1       consumer accepts the word when out_valid=1
//   overrun       out  1       1-cycle pulse: completed word dropped, output full
//   parity_err    out  1       1-cycle pulse: parity mismatch
//   busy          out  1       1 while a frame is in progress
// -----------------------------------------------------------------------------
module serial_to_parallel_receiver #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] parallel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Even parity over data plus parity bit: the XOR of all bits must be zero.
  function automatic logic parity_ok(input logic [DATA_W-1:0] word, input logic par_bit);
    parity_ok = ~(^{word, par_bit});
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
  } state_t;
`endif

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] parallel_r;
  logic              out_valid_r;
  logic              overrun_r;
  logic              busy_r;

  logic [DATA_W-1:0] shift_next_s;
  logic              last_bit_s;
  logic              capture_s;
  logic [DATA_W-1:0] cap_word_s;
  logic              accept_s;
  logic              overrun_s;
`ifdef PARITY_CHECK_EN
  logic              perr_s;
  logic              parity_err_r;
`endif

  // New bits enter at the MSB so that after DATA_W shifts the first bit is the LSB.
  assign shift_next_s = {serial_in, shift_r[DATA_W-1:1]};
  assign last_bit_s   = (bit_cnt_r == CNT_W'(DATA_W - 1));

  // Decide whether this edge completes a word, and which word it is.
  always_comb begin
    capture_s  = 1'b0;
    cap_word_s = shift_next_s;
`ifdef PARITY_CHECK_EN
    perr_s     = 1'b0;
`endif
    case (state_r)
      ST_DATA: begin
        if (bit_en && last_bit_s) begin
`ifdef PARITY_CHECK_EN
          capture_s = 1'b0;
`else
          capture_s = 1'b1;
`endif
        end else begin
          capture_s = 1'b0;
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        // The data word is already complete; the parity bit is not part of it.
        cap_word_s = shift_r;
        if (bit_en) begin
          if (parity_ok(shift_r, serial_in)) begin
            capture_s = 1'b1;
          end else begin
            perr_s = 1'b1;
          end
        end else begin
          capture_s = 1'b0;
        end
      end
`endif
      default: begin
        capture_s = 1'b0;
      end
    endcase
  end

  // A completed word is taken when the output register is empty or being drained now.
  assign accept_s  = capture_s & (~out_valid_r | out_ready);
  assign overrun_s = capture_s & ~accept_s;

  // Receive FSM, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= {DATA_W{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      parallel_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      overrun_r <= overrun_s;
`ifdef PARITY_CHECK_EN
      parity_err_r <= perr_s;
`endif

      // Output register: a capture wins over a plain consume on the same edge.
      if (accept_s) begin
        parallel_r  <= cap_word_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (bit_en && serial_in) begin
            state_r   <= ST_DATA;
            shift_r   <= {DATA_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_bit_s) begin
`ifdef PARITY_CHECK_EN
              state_r <= ST_PARITY;
              busy_r  <= 1'b1;
`else
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
`endif
            end else begin
              busy_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        ST_PARITY: begin
          if (bit_en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign parallel_out = parallel_r;
  assign out_valid    = out_valid_r;
  assign overrun      = overrun_r;
  assign busy         = busy_r;
`ifdef PARITY_CHECK_EN
  assign parity_err   = parity_err_r;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
